// File: rtl/rv32i_exec_ctrl.sv
// rv32i_exec_ctrl
//   RV32I decode/execute slice: opcode/funct decode into datapath controls,
//   a 32-bit ALU and a branch comparator. imm_sel is combinational so the
//   external immediate generator can produce imm in the same cycle; every
//   other output is registered with one cycle of latency.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid               instr/operands valid this cycle
//   instr, pc              instruction word and its PC
//   rs1_data, rs2_data     register file read data
//   imm                    sign-extended immediate (built using imm_sel)
//   imm_sel                combinational immediate format I/S/B/U/J
//   out_valid              registered in_valid
//   alu_result/zero/sign   registered ALU result and flags
//   branch_taken, pc_sel   comparator result / take-target select
//   a_sel, b_sel, br_un    operand selects, unsigned compare
//   mem_rw, reg_wen        store strobe, register write enable
//   wb_sel, alu_control    write-back source, ALU op used
//   illegal                unrecognised opcode
module rv32i_exec_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  output logic [2:0]      imm_sel,
  output logic            out_valid,
  output logic [XLEN-1:0] alu_result,
  output logic            alu_zero,
  output logic            alu_sign,
  output logic            branch_taken,
  output logic            pc_sel,
  output logic            a_sel,
  output logic            b_sel,
  output logic            br_un,
  output logic            mem_rw,
  output logic            reg_wen,
  output logic [1:0]      wb_sel,
  output logic [3:0]      alu_control,
  output logic            illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_SLL   = 4'b0010;
  localparam logic [3:0] ALU_SLT   = 4'b0011;
  localparam logic [3:0] ALU_SLTU  = 4'b0100;
  localparam logic [3:0] ALU_XOR   = 4'b0101;
  localparam logic [3:0] ALU_SRL   = 4'b0110;
  localparam logic [3:0] ALU_SRA   = 4'b0111;
  localparam logic [3:0] ALU_OR    = 4'b1000;
  localparam logic [3:0] ALU_AND   = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;

  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign funct7_b5 = instr[30];

  // funct7[5] selects SUB only for register-register ops; for immediates it
  // is part of the immediate except on the right shifts (SRAI vs SRLI).
  function automatic logic [3:0] funct_alu(input logic [2:0] f3, input logic alt,
                                           input logic is_reg);
    case (f3)
      3'b000:  funct_alu = (is_reg && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  funct_alu = ALU_SLL;
      3'b010:  funct_alu = ALU_SLT;
      3'b011:  funct_alu = ALU_SLTU;
      3'b100:  funct_alu = ALU_XOR;
      3'b101:  funct_alu = alt ? ALU_SRA : ALU_SRL;
      3'b110:  funct_alu = ALU_OR;
      default: funct_alu = ALU_AND;
    endcase
  endfunction

  logic [2:0] imm_sel_c;
  logic       a_c, b_c, wen_c, mem_c, jump_c, branch_c, ill_c;
  logic [1:0] wb_c;
  logic [3:0] alu_c;

  always_comb begin
    imm_sel_c = IMM_I;
    a_c       = 1'b0;
    b_c       = 1'b0;
    wb_c      = 2'b00;
    wen_c     = 1'b0;
    mem_c     = 1'b0;
    alu_c     = ALU_ADD;
    jump_c    = 1'b0;
    branch_c  = 1'b0;
    ill_c     = 1'b0;
    case (opcode)
      OPC_OP: begin
        wb_c = 2'b01; wen_c = 1'b1;
        alu_c = funct_alu(funct3, funct7_b5, 1'b1);
      end
      OPC_OP_IMM: begin
        b_c = 1'b1; wb_c = 2'b01; wen_c = 1'b1;
        alu_c = funct_alu(funct3, funct7_b5, 1'b0);
      end
      OPC_LOAD: begin
        b_c = 1'b1; wb_c = 2'b00; wen_c = 1'b1;
      end
      OPC_STORE: begin
        imm_sel_c = IMM_S; b_c = 1'b1; mem_c = 1'b1;
      end
      OPC_BRANCH: begin
        imm_sel_c = IMM_B; a_c = 1'b1; b_c = 1'b1; branch_c = 1'b1;
      end
      OPC_JAL: begin
        imm_sel_c = IMM_J; a_c = 1'b1; b_c = 1'b1; wb_c = 2'b10; wen_c = 1'b1;
        jump_c = 1'b1;
      end
      OPC_JALR: begin
        b_c = 1'b1; wb_c = 2'b10; wen_c = 1'b1; jump_c = 1'b1;
      end
      OPC_LUI: begin
        imm_sel_c = IMM_U; b_c = 1'b1; wb_c = 2'b01; wen_c = 1'b1;
        alu_c = ALU_PASSB;
      end
      OPC_AUIPC: begin
        imm_sel_c = IMM_U; a_c = 1'b1; b_c = 1'b1; wb_c = 2'b01; wen_c = 1'b1;
      end
      default: ill_c = 1'b1;
    endcase
  end

  assign imm_sel = imm_sel_c;

  logic [XLEN-1:0] op_a, op_b, alu_res;
  logic [4:0]      shamt;

  assign op_a  = a_c ? pc : rs1_data;
  assign op_b  = b_c ? imm : rs2_data;
  assign shamt = op_b[4:0];

  always_comb begin
    alu_res = '0;
    case (alu_c)
      ALU_ADD:   alu_res = op_a + op_b;
      ALU_SUB:   alu_res = op_a - op_b;
      ALU_SLL:   alu_res = op_a << shamt;
      ALU_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      ALU_SLTU:  alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      ALU_XOR:   alu_res = op_a ^ op_b;
      ALU_SRL:   alu_res = op_a >> shamt;
      ALU_SRA:   alu_res = XLEN'($signed(op_a) >>> shamt);
      ALU_OR:    alu_res = op_a | op_b;
      ALU_AND:   alu_res = op_a & op_b;
      ALU_PASSB: alu_res = op_b;
      default:   alu_res = '0;
    endcase
  end

  // Comparator always looks at the raw register values; the ALU operands
  // are busy computing the branch target.
  logic cmp_eq, cmp_lt, cmp_ltu, cmp_c;

  assign cmp_eq  = (rs1_data == rs2_data);
  assign cmp_lt  = ($signed(rs1_data) < $signed(rs2_data));
  assign cmp_ltu = (rs1_data < rs2_data);

  always_comb begin
    case (funct3)
      3'b000:  cmp_c = cmp_eq;
      3'b001:  cmp_c = ~cmp_eq;
      3'b100:  cmp_c = cmp_lt;
      3'b101:  cmp_c = ~cmp_lt;
      3'b110:  cmp_c = cmp_ltu;
      3'b111:  cmp_c = ~cmp_ltu;
      default: cmp_c = 1'b0;
    endcase
  end

  logic taken_c;
  assign taken_c = branch_c ? cmp_c : jump_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      alu_result   <= '0;
      alu_zero     <= 1'b0;
      alu_sign     <= 1'b0;
      branch_taken <= 1'b0;
      pc_sel       <= 1'b0;
      a_sel        <= 1'b0;
      b_sel        <= 1'b0;
      br_un        <= 1'b0;
      mem_rw       <= 1'b0;
      reg_wen      <= 1'b0;
      wb_sel       <= 2'b00;
      alu_control  <= 4'b0000;
      illegal      <= 1'b0;
    end else begin
      out_valid    <= in_valid;
      alu_result   <= alu_res;
      alu_zero     <= (alu_res == '0);
      alu_sign     <= alu_res[XLEN-1];
      branch_taken <= taken_c;
      // Side-effecting controls are squashed for bubbles.
      pc_sel       <= in_valid & taken_c;
      a_sel        <= a_c;
      b_sel        <= b_c;
      br_un        <= branch_c & funct3[2] & funct3[1];
      mem_rw       <= in_valid & mem_c;
      reg_wen      <= in_valid & wen_c;
      wb_sel       <= wb_c;
      alu_control  <= alu_c;
      illegal      <= ill_c;
    end
  end

endmodule

// File: tb/tb_rv32i_exec_ctrl.sv
// Scoreboard bench for rv32i_exec_ctrl: directed cases followed by random
// instructions, checked against an instruction-level reference model.
module tb_rv32i_exec_ctrl;

  logic        clk, rst_n, in_valid, clk_en;
  logic [31:0] instr, pc, rs1_data, rs2_data, imm;
  logic [2:0]  imm_sel;
  logic        out_valid, alu_zero, alu_sign, branch_taken, pc_sel;
  logic        a_sel, b_sel, br_un, mem_rw, reg_wen, illegal;
  logic [31:0] alu_result;
  logic [1:0]  wb_sel;
  logic [3:0]  alu_control;

  int errors = 0;
  int checks = 0;

  rv32i_exec_ctrl #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .instr(instr), .pc(pc),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .imm_sel(imm_sel),
    .out_valid(out_valid), .alu_result(alu_result), .alu_zero(alu_zero),
    .alu_sign(alu_sign), .branch_taken(branch_taken), .pc_sel(pc_sel),
    .a_sel(a_sel), .b_sel(b_sel), .br_un(br_un), .mem_rw(mem_rw),
    .reg_wen(reg_wen), .wb_sel(wb_sel), .alu_control(alu_control),
    .illegal(illegal)
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  typedef struct packed {
    logic        valid;
    logic [31:0] res;
    logic        zero, sign, taken, pcs, asel, bsel, brun, mrw, wen;
    logic [1:0]  wb;
    logic [3:0]  aluc;
    logic        ill;
  } exp_t;

  exp_t sb[$];

  typedef enum {M_ADD, M_SUB, M_SLL, M_SLT, M_SLTU, M_XOR, M_SRL, M_SRA,
                M_OR, M_AND, M_PASSB} mnem_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic mnem_t arith_name(input logic [2:0] f3, input logic alt, input logic reg_op);
    mnem_t m;
    case (f3)
      3'd0: m = (reg_op && alt) ? M_SUB : M_ADD;
      3'd1: m = M_SLL;
      3'd2: m = M_SLT;
      3'd3: m = M_SLTU;
      3'd4: m = M_XOR;
      3'd5: m = alt ? M_SRA : M_SRL;
      3'd6: m = M_OR;
      default: m = M_AND;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] code_of(input mnem_t m);
    case (m)
      M_ADD:  return 4'd0;  M_SUB:  return 4'd1;  M_SLL: return 4'd2;
      M_SLT:  return 4'd3;  M_SLTU: return 4'd4;  M_XOR: return 4'd5;
      M_SRL:  return 4'd6;  M_SRA:  return 4'd7;  M_OR:  return 4'd8;
      M_AND:  return 4'd9;  default: return 4'd10;
    endcase
  endfunction

  function automatic logic [31:0] apply(input mnem_t m, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb_;
    int sh;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    sh  = int'(b % 32);
    case (m)
      M_ADD:  return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
      M_SUB:  return 32'((64'h1_0000_0000 + 64'(a) - 64'(b)) % 64'h1_0000_0000);
      M_SLL:  return 32'((64'(a) * (64'd1 << sh)) % 64'h1_0000_0000);
      M_SLT:  return (sa < sb_) ? 32'd1 : 32'd0;
      M_SLTU: return (a < b) ? 32'd1 : 32'd0;
      M_XOR:  return a ^ b;
      M_SRL:  return 32'(64'(a) / (64'd1 << sh));
      M_SRA:  return (a[31] && sh != 0) ? (32'(64'(a) / (64'd1 << sh)) | ~(32'hFFFF_FFFF >> sh))
                                        : 32'(64'(a) / (64'd1 << sh));
      M_OR:   return a | b;
      M_AND:  return a & b;
      default: return b;
    endcase
  endfunction

  function automatic logic branch_cond(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (f3)
      3'd0: return x == y;
      3'd1: return x != y;
      3'd4: return sx < sy;
      3'd5: return sx >= sy;
      3'd6: return x < y;
      3'd7: return x >= y;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] exp_imm_sel(input logic [6:0] opc);
    case (opc)
      7'b0100011: return 3'b001;
      7'b1100011: return 3'b010;
      7'b0110111, 7'b0010111: return 3'b011;
      7'b1101111: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic exp_t model(input logic v, input logic [31:0] ins, input logic [31:0] p,
                                 input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im);
    exp_t e;
    mnem_t m;
    logic [31:0] a, b;
    logic [2:0] f3;
    e = '0;
    m = M_ADD;
    a = r1;
    b = r2;
    f3 = ins[14:12];
    e.valid = v;
    case (ins[6:0])
      7'b0110011: begin e.wen = 1; e.wb = 2'b01; m = arith_name(f3, ins[30], 1'b1); end
      7'b0010011: begin e.wen = 1; e.wb = 2'b01; e.bsel = 1; b = im;
                        m = arith_name(f3, ins[30], 1'b0); end
      7'b0000011: begin e.wen = 1; e.wb = 2'b00; e.bsel = 1; b = im; end
      7'b0100011: begin e.mrw = 1; e.bsel = 1; b = im; end
      7'b1100011: begin e.asel = 1; e.bsel = 1; a = p; b = im;
                        e.taken = branch_cond(f3, r1, r2); e.pcs = e.taken;
                        e.brun = (f3 == 3'd6 || f3 == 3'd7); end
      7'b1101111: begin e.asel = 1; e.bsel = 1; a = p; b = im; e.wen = 1; e.wb = 2'b10;
                        e.taken = 1; e.pcs = 1; end
      7'b1100111: begin e.bsel = 1; b = im; e.wen = 1; e.wb = 2'b10; e.taken = 1; e.pcs = 1; end
      7'b0110111: begin e.bsel = 1; b = im; e.wen = 1; e.wb = 2'b01; m = M_PASSB; end
      7'b0010111: begin e.asel = 1; e.bsel = 1; a = p; b = im; e.wen = 1; e.wb = 2'b01; end
      default:    e.ill = 1;
    endcase
    e.aluc = code_of(m);
    e.res  = apply(m, a, b);
    e.zero = (e.res == 32'd0);
    e.sign = e.res[31];
    if (!v) begin e.wen = 0; e.mrw = 0; e.pcs = 0; end
    return e;
  endfunction

  task automatic issue(input logic v, input logic [31:0] ins, input logic [31:0] p,
                       input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                       input logic has_c, input logic [31:0] c_res);
    exp_t e;
    @(negedge clk);
    in_valid = v; instr = ins; pc = p; rs1_data = r1; rs2_data = r2; imm = im;
    e = model(v, ins, p, r1, r2, im);
    if (has_c) begin
      e.res = c_res; e.zero = (c_res == 32'd0); e.sign = c_res[31];
    end
    #1;
    chk("imm_sel", 32'(imm_sel), 32'(exp_imm_sel(ins[6:0])));
    sb.push_back(e);
  endtask

  task automatic check_reset_outputs();
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst alu_result", alu_result, 32'd0);
    chk("rst alu_zero", 32'(alu_zero), 32'd0);
    chk("rst alu_sign", 32'(alu_sign), 32'd0);
    chk("rst branch_taken", 32'(branch_taken), 32'd0);
    chk("rst pc_sel", 32'(pc_sel), 32'd0);
    chk("rst a_sel", 32'(a_sel), 32'd0);
    chk("rst b_sel", 32'(b_sel), 32'd0);
    chk("rst br_un", 32'(br_un), 32'd0);
    chk("rst mem_rw", 32'(mem_rw), 32'd0);
    chk("rst reg_wen", 32'(reg_wen), 32'd0);
    chk("rst wb_sel", 32'(wb_sel), 32'd0);
    chk("rst alu_control", 32'(alu_control), 32'd0);
    chk("rst illegal", 32'(illegal), 32'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain timeout: %0d entries left expected 0", sb.size());
      sb.delete();
    end
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 6))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0001;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] opc);
    return {f7, 5'd2, 5'd1, f3, 5'd3, opc};
  endfunction

  // Monitor: compares every registered output whenever a result is pending.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("out_valid", 32'(out_valid), 32'(e.valid));
        chk("alu_result", alu_result, e.res);
        chk("alu_zero", 32'(alu_zero), 32'(e.zero));
        chk("alu_sign", 32'(alu_sign), 32'(e.sign));
        chk("branch_taken", 32'(branch_taken), 32'(e.taken));
        chk("pc_sel", 32'(pc_sel), 32'(e.pcs));
        chk("a_sel", 32'(a_sel), 32'(e.asel));
        chk("b_sel", 32'(b_sel), 32'(e.bsel));
        chk("br_un", 32'(br_un), 32'(e.brun));
        chk("mem_rw", 32'(mem_rw), 32'(e.mrw));
        chk("reg_wen", 32'(reg_wen), 32'(e.wen));
        chk("wb_sel", 32'(wb_sel), 32'(e.wb));
        chk("alu_control", 32'(alu_control), 32'(e.aluc));
        chk("illegal", 32'(illegal), 32'(e.ill));
      end
    end
  end

  initial begin
    logic [6:0]  opc;
    logic [31:0] ins, r1, r2;
    clk_en = 1'b1;
    rst_n = 1'b0;
    in_valid = 1'b0; instr = '0; pc = '0; rs1_data = '0; rs2_data = '0; imm = '0;
    #1;
    check_reset_outputs();
    #11;
    rst_n = 1'b1;

    // Directed cases with hand-derived results.
    issue(1, mk(7'b0100000, 3'b000, 7'b0110011), 32'h0, 32'd5, 32'd7, 32'h0, 1, 32'hFFFF_FFFE);
    issue(1, mk(7'b0100000, 3'b101, 7'b0010011), 32'h0, 32'h8000_0000, 32'h0, 32'h404, 1, 32'hF800_0000);
    issue(1, mk(7'b0000000, 3'b101, 7'b0010011), 32'h0, 32'h8000_0000, 32'h0, 32'h4, 1, 32'h0800_0000);
    issue(1, mk(7'b0000000, 3'b100, 7'b1100011), 32'h100, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8, 1, 32'h0000_00F8);
    issue(1, mk(7'b0000000, 3'b110, 7'b1100011), 32'h100, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8, 1, 32'h0000_00F8);
    issue(1, mk(7'b0000000, 3'b010, 7'b0100011), 32'h0, 32'h1000, 32'h55, 32'h10, 1, 32'h0000_1010);
    issue(1, mk(7'b0000000, 3'b000, 7'b1101111), 32'h20, 32'h0, 32'h0, 32'h40, 1, 32'h0000_0060);
    issue(1, mk(7'b0000000, 3'b000, 7'b1111111), 32'h0, 32'd3, 32'd4, 32'h0, 1, 32'h0000_0007);
    issue(0, mk(7'b0000000, 3'b000, 7'b0110011), 32'h0, 32'd3, 32'd4, 32'h0, 1, 32'h0000_0007);
    issue(1, mk(7'b0000000, 3'b000, 7'b0110111), 32'h0, 32'd3, 32'd4, 32'hABCD_E000, 1, 32'hABCD_E000);
    issue(1, mk(7'b0000000, 3'b000, 7'b0110011), 32'h0, 32'hFFFF_FFFF, 32'd1, 32'h0, 1, 32'h0000_0000);
    drain();

    // Asynchronous reset with the clock stopped.
    issue(1, mk(7'b0000000, 3'b001, 7'b1100011), 32'h40, 32'd1, 32'd2, 32'h10, 0, 32'h0);
    drain();
    clk_en = 1'b0;
    #3 rst_n = 1'b0;
    #1 check_reset_outputs();
    #3 rst_n = 1'b1;
    #2 clk_en = 1'b1;

    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 10))
        0: opc = 7'b0110011;  1: opc = 7'b0010011;  2: opc = 7'b0000011;
        3: opc = 7'b0100011;  4: opc = 7'b1100011;  5: opc = 7'b1101111;
        6: opc = 7'b1100111;  7: opc = 7'b0110111;  8: opc = 7'b0010111;
        9: opc = 7'b1111111;
        default: opc = 7'($urandom);
      endcase
      ins = {$urandom} & 32'hFFFF_FF80;
      ins[6:0] = opc;
      r1 = rnd_val();
      r2 = ($urandom_range(0, 3) == 0) ? r1 : rnd_val();
      issue(($urandom_range(0, 7) != 0), ins, $urandom, r1, r2, rnd_val(), 0, 32'h0);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
